traffic_light: RTL and testbench

//   Two-road intersection controller (road A, road B) with a pedestrian walk phase.
//   A fixed-time Moore FSM cycles A green/yellow, B green/yellow, walk, walk-flash.

---
 rtl/traffic_light.sv | 134 +++++++++++++
 tb/tb_traffic_light.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/traffic_light.sv
// rtl/traffic_light.sv - two-road fixed-time traffic light controller with pedestrian walk phase
module traffic_light #(
    parameter int HALF_SEC_CYCLES = 50_000_000,
    parameter int T_GREEN         = 5,
    parameter int T_YELLOW        = 2,
    parameter int T_WALK          = 3,
    parameter int T_FLASH         = 3
) (
    input  logic clk,
    input  logic rst,
    output logic Ga,
    output logic Ya,
    output logic Ra,
    output logic Gb,
    output logic Yb,
    output logic Rb,
    output logic Gw,
    output logic Rw
);

    // The second counter only ever has to reach the longest state duration minus one.
    localparam int TMAX_GY = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
    localparam int TMAX_WF = (T_WALK > T_FLASH) ? T_WALK : T_FLASH;
    localparam int TMAX    = (TMAX_GY > TMAX_WF) ? TMAX_GY : TMAX_WF;
    localparam int PW      = (HALF_SEC_CYCLES > 1) ? $clog2(HALF_SEC_CYCLES) : 1;
    localparam int CW      = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [PW-1:0] PRE_MAX = PW'(HALF_SEC_CYCLES - 1);

    typedef enum logic [2:0] {
        A_GRN = 3'd0,
        A_YEL = 3'd1,
        B_GRN = 3'd2,
        B_YEL = 3'd3,
        WALK  = 3'd4,
        FLASH = 3'd5
    } state_e;

    state_e        state_q, state_d;
    state_e        next_state;
    logic [PW-1:0] pre_q, pre_d;
    logic          phase_q, phase_d;
    logic [CW-1:0] sec_q, sec_d;
    logic [CW-1:0] limit;
    logic          half_tick;
    logic          sec_tick;
    logic          illegal;

    // State, prescaler, half-second phase and second counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= A_GRN;
            pre_q   <= '0;
            phase_q <= 1'b0;
            sec_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            phase_q <= phase_d;
            sec_q   <= sec_d;
        end
    end

    // Tick generation, state sequencing and Moore lamp decode from state and phase.
    always_comb begin
        half_tick  = (pre_q == PRE_MAX);
        sec_tick   = half_tick & phase_q;
        pre_d      = half_tick ? '0 : pre_q + 1'b1;
        phase_d    = phase_q ^ half_tick;

        limit      = CW'(T_GREEN - 1);
        next_state = A_GRN;
        illegal    = 1'b0;
        Ga = 1'b0; Ya = 1'b0; Ra = 1'b0;
        Gb = 1'b0; Yb = 1'b0; Rb = 1'b0;
        Gw = 1'b0; Rw = 1'b0;

        case (state_q)
            A_GRN: begin
                limit      = CW'(T_GREEN - 1);
                next_state = A_YEL;
                Ga = 1'b1; Rb = 1'b1; Rw = 1'b1;
            end
            A_YEL: begin
                limit      = CW'(T_YELLOW - 1);
                next_state = B_GRN;
                Ya = 1'b1; Rb = 1'b1; Rw = 1'b1;
            end
            B_GRN: begin
                limit      = CW'(T_GREEN - 1);
                next_state = B_YEL;
                Gb = 1'b1; Ra = 1'b1; Rw = 1'b1;
            end
            B_YEL: begin
                limit      = CW'(T_YELLOW - 1);
                next_state = WALK;
                Yb = 1'b1; Ra = 1'b1; Rw = 1'b1;
            end
            WALK: begin
                limit      = CW'(T_WALK - 1);
                next_state = FLASH;
                Ra = 1'b1; Rb = 1'b1; Gw = 1'b1;
            end
            FLASH: begin
                limit      = CW'(T_FLASH - 1);
                next_state = A_GRN;
                Ra = 1'b1; Rb = 1'b1; Rw = ~phase_q;
            end
            default: begin
                // Unused encodings show all-red for their single cycle, then restart.
                limit      = '0;
                next_state = A_GRN;
                illegal    = 1'b1;
                Ra = 1'b1; Rb = 1'b1; Rw = 1'b1;
            end
        endcase

        state_d = state_q;
        sec_d   = sec_q;
        if (sec_tick) begin
            if (sec_q == limit) begin
                state_d = next_state;
                sec_d   = '0;
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
        if (illegal) begin
            state_d = A_GRN;
            sec_d   = '0;
        end
    end

endmodule

// File: tb/tb_traffic_light.sv
// tb/tb_traffic_light.sv - directed self-checking bench for traffic_light
module tb_traffic_light;

    localparam logic [7:0] L_A_GRN = 8'b1000_0101;
    localparam logic [7:0] L_A_YEL = 8'b0100_0101;
    localparam logic [7:0] L_B_GRN = 8'b0011_0001;
    localparam logic [7:0] L_B_YEL = 8'b0010_1001;
    localparam logic [7:0] L_WALK  = 8'b0010_0110;

    logic clk;
    logic rst;
    logic rst2;
    logic Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw;
    logic Ga2, Ya2, Ra2, Gb2, Yb2, Rb2, Gw2, Rw2;
    logic [7:0] lamps;
    logic [7:0] lamps2;

    int vectors;
    int miscompares;

    assign lamps  = {Ga, Ya, Ra, Gb, Yb, Rb, Gw, Rw};
    assign lamps2 = {Ga2, Ya2, Ra2, Gb2, Yb2, Rb2, Gw2, Rw2};

    traffic_light #(.HALF_SEC_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .Ga(Ga), .Ya(Ya), .Ra(Ra), .Gb(Gb), .Yb(Yb), .Rb(Rb), .Gw(Gw), .Rw(Rw)
    );

    traffic_light #(.HALF_SEC_CYCLES(1), .T_YELLOW(1)) dut2 (
        .clk(clk), .rst(rst2),
        .Ga(Ga2), .Ya(Ya2), .Ra(Ra2), .Gb(Gb2), .Yb(Yb2), .Rb(Rb2), .Gw(Gw2), .Rw(Rw2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected lamps after the k-th rising edge since reset release; s = clocks per second.
    function automatic logic [7:0] expected(int k, int s, int ty);
        int b1, b2, b3, b4, b5, per, m;
        logic r;
        b1  = 5 * s;
        b2  = b1 + ty * s;
        b3  = b2 + 5 * s;
        b4  = b3 + ty * s;
        b5  = b4 + 3 * s;
        per = b5 + 3 * s;
        m   = k % per;
        if (m < b1) return L_A_GRN;
        if (m < b2) return L_A_YEL;
        if (m < b3) return L_B_GRN;
        if (m < b4) return L_B_YEL;
        if (m < b5) return L_WALK;
        r = (((m - b5) % s) < (s / 2));
        return {7'b0010_010, r};
    endfunction

    function automatic logic safe(logic [7:0] l);
        return ($countones(l[7:5]) == 1) && ($countones(l[4:2]) == 1) &&
               !((l[7] | l[6]) && (l[4] | l[3])) &&
               (!l[1] || (l[5] && l[2])) && !(l[1] && l[0]);
    endfunction

    task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_safe(string tag, logic [7:0] obs);
        vectors++;
        assert (safe(obs) === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: observed lamps %b violate invariants, expected safe=1", tag, obs);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst  = 1'b0;
        rst2 = 1'b0;

        // Reset held across clock edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset_hold", lamps, L_A_GRN);
        check("reset_hold_dut2", lamps2, L_A_GRN);

        // Three full cycles, every edge checked for lamp pattern and invariants.
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 240; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("cycle k=%0d", k), lamps, expected(k, 4, 2));
            check_safe($sformatf("safe k=%0d", k), lamps);
        end

        // Into B_GRN of the next cycle, then asynchronous reset mid-state.
        for (int k = 241; k <= 275; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("pre_reset k=%0d", k), lamps, expected(k, 4, 2));
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("async_reset", lamps, L_A_GRN);
        repeat (2) @(posedge clk);
        #1;
        check("reset_held_mid", lamps, L_A_GRN);

        // After release A_GRN lasts a full 20 clocks again.
        @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("restart k=%0d", k), lamps, expected(k, 4, 2));
            check_safe($sformatf("restart_safe k=%0d", k), lamps);
        end

        // Short-timing instance: 1 s = 2 clocks, A_YEL one second long.
        @(negedge clk);
        rst2 = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sweep k=%0d", k), lamps2, expected(k, 2, 1));
            check_safe($sformatf("sweep_safe k=%0d", k), lamps2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
